bitrev_reader: RTL

BITREV_READER -- requirements
Module: bitrev_reader

---
 rtl/fft_pkg.sv | 23 ++
 rtl/out_fifo2.sv | 55 +++++
 rtl/bitrev_reader.sv | 109 ++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// Shared definitions for the FFT buffer readers: size limits, reader FSM states,
// and the k-bit address reversal used to fetch samples in bit-reversed order.
package fft_pkg;

  localparam int unsigned MAX_LOG2   = 12;
  localparam int unsigned DEF_ADDR_W = MAX_LOG2;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN
  } state_t;

  // Reversing all MAX_LOG2 bits and shifting right by MAX_LOG2-k
  // reverses only the low k bits and leaves the upper bits zero.
  function automatic logic [MAX_LOG2-1:0] bit_rev(input logic [MAX_LOG2-1:0] idx,
                                                  input logic [3:0]          k);
    logic [MAX_LOG2-1:0] full;
    full = {<<{idx}};
    return full >> (MAX_LOG2 - 32'(k));
  endfunction

endpackage

// File: rtl/out_fifo2.sv
// Two-entry output buffer with valid/ready on both sides; the head entry stays
// stable until it is popped.
module out_fifo2 #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic [W-1:0] slot0, slot1;
  logic [1:0]   cnt;
  logic         push, pop;

  assign in_ready  = (cnt != 2'd2);
  assign out_valid = (cnt != 2'd0);
  assign out_data  = slot0;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot0 <= '0;
      slot1 <= '0;
      cnt   <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt == 2'd0) slot0 <= in_data;
          else             slot1 <= in_data;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          cnt   <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) begin
            slot0 <= in_data;
          end else begin
            slot0 <= slot1;
            slot1 <= in_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/bitrev_reader.sv
// Reads a 2^k-point frame out of the sample buffer in bit-reversed address order
// and streams it downstream with natural-order indices over valid/ready.
module bitrev_reader
  import fft_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        len_log2,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] o_data,
  output logic [ADDR_W-1:0] o_index,
  output logic              o_valid,
  input  logic              o_ready,
  output logic              o_last,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned FW = DATA_W + ADDR_W + 1;

  state_t            state, state_nx;
  logic [3:0]        k_q;
  logic [ADDR_W-1:0] idx_q, idx_nx, last_idx, all_ones;
  logic              rd_vld, pend_last;
  logic [ADDR_W-1:0] pend_idx;
  logic              f_in_ready, f_out_valid, f_pop;
  logic [FW-1:0]     f_out;
  logic [1:0]        occ;
  logic              k_ok, accept, issue_last, head_last;

  assign k_ok     = (len_log2 != 4'd0) && (32'(len_log2) <= ADDR_W);
  assign accept   = start && (state == IDLE) && !done && k_ok;
  assign all_ones = '1;
  assign last_idx = ~(all_ones << k_q);

  assign head_last = f_out[0];
  assign o_index   = f_out[ADDR_W:1];
  assign o_data    = f_out[FW-1:ADDR_W+1];
  assign o_valid   = f_out_valid;
  assign o_last    = f_out_valid && head_last;
  assign f_pop     = f_out_valid && o_ready;

  // Occupancy after this cycle: words held (out_valid + full) plus the read
  // landing now, minus a pop happening now. Counting the pop sustains 1 beat/cycle.
  assign occ        = 2'(f_out_valid) + 2'(!f_in_ready) + 2'(rd_vld) - 2'(f_pop);
  assign rd_en      = (state == READ) && (occ < 2'd2);
  assign rd_addr    = ADDR_W'(bit_rev(MAX_LOG2'(idx_q), k_q));
  assign issue_last = rd_en && (idx_q == last_idx);
  assign busy       = (state != IDLE) || done;

  always_comb begin
    state_nx = state;
    idx_nx   = idx_q;
    case (state)
      IDLE:  if (accept) state_nx = READ;
      READ: begin
        if (rd_en) idx_nx = issue_last ? '0 : idx_q + 1'b1;
        if (issue_last) state_nx = DRAIN;
      end
      DRAIN: if (f_pop && head_last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx_q     <= '0;
      k_q       <= '0;
      rd_vld    <= 1'b0;
      pend_idx  <= '0;
      pend_last <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state  <= state_nx;
      idx_q  <= idx_nx;
      rd_vld <= rd_en;
      if (accept) k_q <= len_log2;
      if (rd_en) begin
        pend_idx  <= idx_q;
        pend_last <= issue_last;
      end
      done <= (state == DRAIN) && f_pop && head_last;
      err  <= start && !accept;
    end
  end

  out_fifo2 #(
    .W(FW)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .in_valid (rd_vld),
    .in_ready (f_in_ready),
    .in_data  ({rd_data, pend_idx, pend_last}),
    .out_valid(f_out_valid),
    .out_ready(o_ready),
    .out_data (f_out)
  );

endmodule
